// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, reset PC, NOP word and FSM states for instruction fetch
package ifu_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int INS_WIDTH = 32;

    localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [INS_WIDTH-1:0] NOP_INS          = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC holder issuing one 64-bit read per instruction, valid/ready to decode
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INS_WIDTH-1:0] NOP_INS  = ifu_pkg::NOP_INS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_en,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 if_req_valid,
    input  logic                 if_req_ready,
    output logic [CPU_WIDTH-1:0] if_req_addr,
    input  logic                 if_rsp_valid,
    input  logic [63:0]          if_rsp_data,
    input  logic                 if_rsp_err,
    output logic                 o_ins_valid,
    input  logic                 i_ins_ready,
    output logic [INS_WIDTH-1:0] o_ins,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_fetch_err
);

    ifu_state_t           state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic                 drop_q, drop_d;
    logic [CPU_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [INS_WIDTH-1:0] ins_q, ins_d;
    logic [CPU_WIDTH-1:0] opc_q, opc_d;
    logic                 err_q, err_d;
    logic [INS_WIDTH-1:0] rsp_word;

    assign rsp_word    = pc_q[2] ? if_rsp_data[63:32] : if_rsp_data[31:0];
    assign o_ins_valid = (state_q == HOLD);
    assign o_ins       = ins_q;
    assign o_pc        = opc_q;
    assign o_fetch_err = err_q;
    assign if_req_addr = if_req_valid ? {pc_q[CPU_WIDTH-1:3], 3'b000} : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            pend_pc_q <= '0;
            ins_q     <= '0;
            opc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            pend_pc_q <= pend_pc_d;
            ins_q     <= ins_d;
            opc_q     <= opc_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        pend_pc_d    = pend_pc_q;
        ins_d        = ins_q;
        opc_d        = opc_q;
        err_d        = err_q;
        if_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_en) pc_d = redirect_pc;
            end
            REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    // Misaligned PC never reaches the bus; a redirect simply retargets it.
                    if (redirect_en) begin
                        pc_d = redirect_pc;
                    end else begin
                        ins_d   = NOP_INS;
                        opc_d   = pc_q;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    if_req_valid = 1'b1;
                    if (redirect_en) begin
                        drop_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                    if (if_req_ready) state_d = WAIT;
                end
            end
            WAIT: begin
                if (if_rsp_valid) begin
                    if (redirect_en) begin
                        pc_d    = redirect_pc;
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (drop_q) begin
                        pc_d    = pend_pc_q;
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        ins_d   = if_rsp_err ? NOP_INS : rsp_word;
                        err_d   = if_rsp_err;
                        opc_d   = pc_q;
                        state_d = HOLD;
                    end
                end else if (redirect_en) begin
                    drop_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (i_ins_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        if_rsp_valid |-> (state_q == WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized checks of ifu_fetch against a PC-sequence model
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_req_valid;
    logic        if_req_ready = 1'b0;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid = 1'b0;
    logic [63:0] if_rsp_data = '0;
    logic        if_rsp_err = 1'b0;
    logic        o_ins_valid;
    logic        i_ins_ready = 1'b0;
    logic [31:0] o_ins;
    logic [63:0] o_pc;
    logic        o_fetch_err;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] salt_lo, salt_hi;
    logic [63:0] model_pc;
    logic [63:0] old_addr;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .o_ins_valid(o_ins_valid), .i_ins_ready(i_ins_ready), .o_ins(o_ins), .o_pc(o_pc),
        .o_fetch_err(o_fetch_err)
    );

    // Memory image: each 64-bit beat is derived from its own address and two per-run salts.
    function automatic logic [63:0] beat(input logic [63:0] a);
        return {a[31:0] ^ salt_hi, a[31:0] ^ salt_lo};
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] pc);
        return {pc[63:3], 3'b000};
    endfunction

    function automatic logic [31:0] exp_ins(input logic [63:0] pc, input logic err);
        logic [63:0] b;
        b = beat(line_of(pc));
        if (err) return NOP;
        return pc[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!if_req_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", {63'd0, if_req_valid}, 64'd1);
    endtask

    task automatic bus_req(input logic [63:0] exp_addr, input int stall);
        wait_req();
        chk("req_addr", if_req_addr, exp_addr);
        if_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("req_stall_valid", {63'd0, if_req_valid}, 64'd1);
            chk("req_stall_addr", if_req_addr, exp_addr);
        end
        if_req_ready = 1'b1;
        @(negedge clk);
        if_req_ready = 1'b0;
    endtask

    task automatic bus_rsp(input logic [63:0] addr, input logic err, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("wait_no_ins", {63'd0, o_ins_valid}, 64'd0);
            chk("wait_no_req", {63'd0, if_req_valid}, 64'd0);
            @(negedge clk);
        end
        if_rsp_valid = 1'b1;
        if_rsp_data  = beat(addr);
        if_rsp_err   = err;
        @(negedge clk);
        if_rsp_valid = 1'b0;
        if_rsp_err   = 1'b0;
        if_rsp_data  = '0;
    endtask

    task automatic check_presented(input logic [63:0] pc, input logic err);
        chk("ins_valid", {63'd0, o_ins_valid}, 64'd1);
        chk("ins_pc", o_pc, pc);
        chk("ins_word", {32'd0, o_ins}, {32'd0, exp_ins(pc, err)});
        chk("ins_err", {63'd0, o_fetch_err}, {63'd0, err});
    endtask

    task automatic expect_ins(input logic [63:0] pc, input logic err, input int hold);
        check_presented(pc, err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_presented(pc, err);
            chk("hold_no_req", {63'd0, if_req_valid}, 64'd0);
        end
        i_ins_ready = 1'b1;
        @(negedge clk);
        i_ins_ready = 1'b0;
        chk("consumed_drop", {63'd0, o_ins_valid}, 64'd0);
    endtask

    task automatic fetch(input int stall, input int delay, input int hold, input logic err);
        bus_req(line_of(model_pc), stall);
        bus_rsp(line_of(model_pc), err, delay);
        expect_ins(model_pc, err, hold);
        model_pc = model_pc + 64'd4;
    endtask

    task automatic redirect_in_hold(input logic [63:0] target, input logic ready);
        redirect_en = 1'b1;
        redirect_pc = target;
        i_ins_ready = ready;
        @(negedge clk);
        redirect_en = 1'b0;
        i_ins_ready = 1'b0;
        chk("redir_hold_drop", {63'd0, o_ins_valid}, 64'd0);
        model_pc = target;
    endtask

    initial begin
        salt_lo = $urandom;
        salt_hi = $urandom ^ 32'h5a5a_0f0f;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", {63'd0, if_req_valid}, 64'd0);
        chk("rst_req_addr", if_req_addr, 64'd0);
        chk("rst_ins_valid", {63'd0, o_ins_valid}, 64'd0);
        chk("rst_ins", {32'd0, o_ins}, 64'd0);
        chk("rst_pc", o_pc, 64'd0);
        chk("rst_err", {63'd0, o_fetch_err}, 64'd0);
        rst_n = 1'b1;
        model_pc = RST_PC;

        // Back-to-back stream with minimum latency
        for (int i = 0; i < 3; i++) fetch(0, 0, 0, 1'b0);
        chk("next_req_latency", {63'd0, if_req_valid}, 64'd1);

        // Decode backpressure
        fetch(0, 0, 5, 1'b0);

        // Redirect while waiting for the response
        bus_req(line_of(model_pc), 0);
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0100;
        @(negedge clk);
        redirect_en = 1'b0;
        bus_rsp(line_of(model_pc), 1'b0, 1);
        chk("wait_redir_no_ins", {63'd0, o_ins_valid}, 64'd0);
        model_pc = 64'h8000_0100;
        fetch(0, 0, 0, 1'b0);

        // Redirect while the request is stalled by the bridge
        wait_req();
        old_addr = line_of(model_pc);
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0200;
        @(negedge clk);
        redirect_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_redir_addr", if_req_addr, old_addr);
            @(negedge clk);
        end
        if_req_ready = 1'b1;
        @(negedge clk);
        if_req_ready = 1'b0;
        bus_rsp(old_addr, 1'b0, 0);
        chk("stall_redir_no_ins", {63'd0, o_ins_valid}, 64'd0);
        model_pc = 64'h8000_0200;
        fetch(0, 0, 0, 1'b0);

        // Redirect coinciding with the response
        bus_req(line_of(model_pc), 0);
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0300;
        if_rsp_valid = 1'b1;
        if_rsp_data = beat(line_of(model_pc));
        @(negedge clk);
        redirect_en = 1'b0;
        if_rsp_valid = 1'b0;
        chk("rsp_redir_no_ins", {63'd0, o_ins_valid}, 64'd0);
        chk("rsp_redir_addr", if_req_addr, 64'h8000_0300);
        model_pc = 64'h8000_0300;
        fetch(1, 2, 1, 1'b0);

        // Redirect in HOLD together with ready, then 64-bit PC wrap
        bus_req(line_of(model_pc), 0);
        bus_rsp(line_of(model_pc), 1'b0, 0);
        check_presented(model_pc, 1'b0);
        redirect_in_hold(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        fetch(0, 0, 0, 1'b0);
        chk("wrap_pc", model_pc, 64'd0);
        fetch(0, 0, 0, 1'b0);

        // Bus error response
        fetch(0, 1, 0, 1'b1);

        // Misaligned redirect: no bus traffic, fault presented twice
        bus_req(line_of(model_pc), 0);
        bus_rsp(line_of(model_pc), 1'b0, 0);
        check_presented(model_pc, 1'b0);
        redirect_in_hold(64'h8000_0002, 1'b0);
        chk("misalign_no_req", {63'd0, if_req_valid}, 64'd0);
        @(negedge clk);
        expect_ins(model_pc, 1'b1, 1);
        chk("misalign2_no_req", {63'd0, if_req_valid}, 64'd0);
        model_pc = model_pc + 64'd4;
        @(negedge clk);
        check_presented(model_pc, 1'b1);
        redirect_in_hold(64'h8000_1000, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a transaction
        bus_req(line_of(model_pc), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", {63'd0, if_req_valid}, 64'd0);
        chk("midrst_ins", {63'd0, o_ins_valid}, 64'd0);
        rst_n = 1'b1;
        model_pc = RST_PC;
        fetch(0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
